multicycle_control_unit: RTL and testbench

//  Sequencer FSM for the RISC-V RV32I multicycle datapath. Decodes instrCode and steps

---
 rtl/multicycle_control_unit_if.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath.
// CTRL_ILLEGAL_TRAP_EN adds the illegalInstr status line.
interface multicycle_control_unit_if;
  logic [31:0] instrCode;
  logic        PCEn;
  logic        regFileWe;
  logic        aluSrcMuxSel;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic        busWe;
  logic [2:0]  busFunct3;
  logic        instrDone;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegalInstr;

  modport master (
    input  instrCode,
    output PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
    output branch, jal, jalr, busWe, busFunct3, instrDone, illegalInstr
  );
  modport slave (
    output instrCode,
    input  PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
    input  branch, jal, jalr, busWe, busFunct3, instrDone, illegalInstr
  );
`else
  modport master (
    input  instrCode,
    output PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
    output branch, jal, jalr, busWe, busFunct3, instrDone
  );
  modport slave (
    output instrCode,
    input  PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
    input  branch, jal, jalr, busWe, busFunct3, instrDone
  );
`endif
endinterface

// File: rtl/multicycle_control_unit.sv
// RV32I multicycle sequencer: FETCH -> DECODE -> EXE [-> MEM -> WB | -> PCUPD].
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcode halts with illegalInstr).
module multicycle_control_unit (
  input  logic clk,
  input  logic reset,
  multicycle_control_unit_if.master bus
);
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXE_ALU, L_EXE, L_MEM, L_WB, S_EXE, S_MEM,
    B_EXE, J_EXE, JL_EXE, PCUPD, HALT
  } state_t;

  state_t     r_state, w_next;
  // Fields latched at the end of DECODE so later instrCode changes are ignored
  logic [6:0] r_op;
  logic [2:0] r_f3;
  logic       r_b30;
  logic [6:0] w_op;
  logic       w_unused_bits;

  assign w_op          = bus.instrCode[6:0];
  assign w_unused_bits = ^{bus.instrCode[31], bus.instrCode[29:15], bus.instrCode[11:7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_op    <= '0;
      r_f3    <= '0;
      r_b30   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) begin
        r_op  <= bus.instrCode[6:0];
        r_f3  <= bus.instrCode[14:12];
        r_b30 <= bus.instrCode[30];
      end
    end
  end

  always_comb begin
    w_next            = r_state;
    bus.PCEn          = 1'b0;
    bus.regFileWe     = 1'b0;
    bus.aluSrcMuxSel  = 1'b0;
    bus.aluControl    = 4'b0000;
    bus.RFWDSrcMuxSel = 3'd0;
    bus.branch        = 1'b0;
    bus.jal           = 1'b0;
    bus.jalr          = 1'b0;
    bus.busWe         = 1'b0;
    bus.busFunct3     = 3'b000;
    bus.instrDone     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    bus.illegalInstr  = 1'b0;
`endif
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: begin
        case (w_op)
          OP_R, OP_I, OP_LU, OP_AU: w_next = EXE_ALU;
          OP_L:    w_next = L_EXE;
          OP_S:    w_next = S_EXE;
          OP_B:    w_next = B_EXE;
          OP_J:    w_next = J_EXE;
          OP_JL:   w_next = JL_EXE;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default: w_next = HALT;
`else
          default: w_next = PCUPD;
`endif
        endcase
      end
      EXE_ALU: begin
        bus.regFileWe = 1'b1;
        bus.PCEn      = 1'b1;
        bus.instrDone = 1'b1;
        case (r_op)
          OP_R: bus.aluControl = {r_b30, r_f3};
          OP_I: begin
            bus.aluSrcMuxSel = 1'b1;
            // bit 30 only distinguishes SRAI from SRLI; other I-types carry imm bits there
            bus.aluControl   = {(r_f3 == 3'b101) & r_b30, r_f3};
          end
          OP_LU:   bus.RFWDSrcMuxSel = 3'd2;
          OP_AU:   bus.RFWDSrcMuxSel = 3'd3;
          default: ;
        endcase
        w_next = FETCH;
      end
      L_EXE: begin
        bus.aluSrcMuxSel = 1'b1;
        w_next           = L_MEM;
      end
      L_MEM: begin
        bus.busFunct3 = r_f3;
        w_next        = L_WB;
      end
      L_WB: begin
        bus.busFunct3     = r_f3;
        bus.RFWDSrcMuxSel = 3'd1;
        bus.regFileWe     = 1'b1;
        bus.PCEn          = 1'b1;
        bus.instrDone     = 1'b1;
        w_next            = FETCH;
      end
      S_EXE: begin
        bus.aluSrcMuxSel = 1'b1;
        w_next           = S_MEM;
      end
      S_MEM: begin
        bus.busFunct3 = r_f3;
        bus.busWe     = 1'b1;
        bus.PCEn      = 1'b1;
        bus.instrDone = 1'b1;
        w_next        = FETCH;
      end
      B_EXE: begin
        bus.aluControl = {1'b0, r_f3};
        bus.branch     = 1'b1;
        w_next         = PCUPD;
      end
      J_EXE: begin
        bus.jal           = 1'b1;
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = 3'd4;
        w_next            = PCUPD;
      end
      JL_EXE: begin
        // Link write and target both happen here; the target uses the pre-write rs1
        bus.jal           = 1'b1;
        bus.jalr          = 1'b1;
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = 3'd4;
        w_next            = PCUPD;
      end
      PCUPD: begin
        bus.PCEn      = 1'b1;
        bus.instrDone = 1'b1;
        w_next        = FETCH;
      end
      HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        bus.illegalInstr = 1'b1;
`endif
        w_next = HALT;
      end
      default: w_next = FETCH;
    endcase

    // A reset cycle must never commit a write or a PC update
    if (reset) begin
      bus.PCEn          = 1'b0;
      bus.regFileWe     = 1'b0;
      bus.aluSrcMuxSel  = 1'b0;
      bus.aluControl    = 4'b0000;
      bus.RFWDSrcMuxSel = 3'd0;
      bus.branch        = 1'b0;
      bus.jal           = 1'b0;
      bus.jalr          = 1'b0;
      bus.busWe         = 1'b0;
      bus.busFunct3     = 3'b000;
      bus.instrDone     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      bus.illegalInstr  = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle model of each instruction's control
// sequence plus literal CPI / ALU-code / bus-write expectations.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if bus();
  multicycle_control_unit dut (.clk(clk), .reset(reset), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_code;
  int          cur_k;
  logic        chk_en;
  logic        exp_zero;
  int          cyc_since = 0;
  int          bwe_cnt = 0;
  int          done_q[$];
  int          exp_cpi_q[$];

  typedef struct {
    logic [31:0] code;
    int          cpi;
    int          alu;
  } vec_t;

  // Expected output vector for cycle k (0 = FETCH) of instruction c.
  // Layout: PCEn,We,AluSrc,AluCtl[4],RFWD[3],br,jal,jalr,busWe,busF3[3],done,illegal
  function automatic logic [18:0] model(input logic [31:0] c, input int k);
    logic [6:0] op = c[6:0];
    logic [2:0] f3 = c[14:12];
    logic pcen = 0, we = 0, src = 0, br = 0, jl = 0, jr = 0, bwe = 0, done = 0, ill = 0;
    logic [3:0] alu = 0;
    logic [2:0] rf = 0, bf = 0;
    bit is_alu = (op inside {7'h33, 7'h13, 7'h37, 7'h17});
    bit known  = is_alu || (op inside {7'h03, 7'h23, 7'h63, 7'h6F, 7'h67});
    if (!known) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      ill = (k >= 2);
`else
      if (k == 2) begin pcen = 1; done = 1; end
`endif
    end else if (k == 2) begin
      case (op)
        7'h33: begin we = 1; pcen = 1; done = 1; alu = {c[30], f3}; end
        7'h13: begin we = 1; pcen = 1; done = 1; src = 1; alu = {(f3 == 3'b101) & c[30], f3}; end
        7'h37: begin we = 1; pcen = 1; done = 1; rf = 3'd2; end
        7'h17: begin we = 1; pcen = 1; done = 1; rf = 3'd3; end
        7'h03, 7'h23: src = 1;
        7'h63: begin alu = {1'b0, f3}; br = 1; end
        7'h6F: begin jl = 1; we = 1; rf = 3'd4; end
        7'h67: begin jl = 1; jr = 1; we = 1; rf = 3'd4; end
        default: ;
      endcase
    end else if (k == 3) begin
      if (op == 7'h03) bf = f3;
      else if (op == 7'h23) begin bf = f3; bwe = 1; pcen = 1; done = 1; end
      else if (op inside {7'h63, 7'h6F, 7'h67}) begin pcen = 1; done = 1; end
    end else if (k == 4 && op == 7'h03) begin
      rf = 3'd1; we = 1; pcen = 1; done = 1; bf = f3;
    end
    return {pcen, we, src, alu, rf, br, jl, jr, bwe, bf, done, ill};
  endfunction

  function automatic logic [18:0] dutv();
    logic ill;
`ifdef CTRL_ILLEGAL_TRAP_EN
    ill = bus.illegalInstr;
`else
    ill = 1'b0;
`endif
    return {bus.PCEn, bus.regFileWe, bus.aluSrcMuxSel, bus.aluControl, bus.RFWDSrcMuxSel,
            bus.branch, bus.jal, bus.jalr, bus.busWe, bus.busFunct3, bus.instrDone, ill};
  endfunction

  always @(negedge clk) begin
    logic [18:0] a, e;
    if (chk_en) begin
      a = dutv();
      e = exp_zero ? 19'd0 : model(cur_code, cur_k);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl code=%h k=%0d got=%b want=%b", cur_code, cur_k, a, e);
      end
    end
    if (reset) cyc_since = 0;
    else begin
      cyc_since++;
      if (bus.instrDone === 1'b1) begin
        done_q.push_back(cyc_since);
        cyc_since = 0;
      end
    end
    if (bus.busWe === 1'b1) bwe_cnt++;
  end

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Drive one instruction for n cycles; instrCode is scrambled after DECODE.
  task automatic run(input logic [31:0] c, input int n, input int lit_alu);
    for (int k = 0; k < n; k++) begin
      cur_code = c; cur_k = k; exp_zero = 1'b0; chk_en = 1'b1;
      bus.instrCode = (k < 2) ? c : ~c;
      @(negedge clk);
      if (k == 2 && lit_alu >= 0) lit($sformatf("aluctl_%h", c), int'(bus.aluControl), lit_alu);
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_cycle();
    exp_zero = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; exp_zero = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    tbl = '{
      '{32'h002081B3, 3, 0},   // ADD  x3,x1,x2
      '{32'h40208233, 3, 8},   // SUB  x4,x1,x2
      '{32'h4030D293, 3, 13},  // SRAI x5,x1,3
      '{32'hFFF08093, 3, 0},   // ADDI x1,x1,-1 (bit30 set, not a shift)
      '{32'h123453B7, 3, 0},   // LUI
      '{32'h00001417, 3, 0},   // AUIPC
      '{32'h00108463, 4, 0},   // BEQ x1,x1,+8
      '{32'h00109463, 4, 1},   // BNE x1,x1,+8
      '{32'h00512023, 4, 0},   // SW x5,0(x2)
      '{32'h00012303, 5, 0},   // LW x6,0(x2)
      '{32'h008000EF, 4, 0},   // JAL x1,8
      '{32'h004080E7, 4, 0}    // JALR x1,4(x1)
    };
    reset = 1'b1; bus.instrCode = '0; chk_en = 1'b0; exp_zero = 1'b1;
    cur_code = '0; cur_k = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; exp_zero = 1'b0;

    foreach (tbl[i]) begin
      run(tbl[i].code, tbl[i].cpi, tbl[i].alu);
      exp_cpi_q.push_back(tbl[i].cpi);
    end

    // Reset during L_MEM abandons the load; the next instruction starts cleanly
    run(32'h00012303, 3, 0);
    reset_cycle();
    run(32'h002081B3, 3, 0);
    exp_cpi_q.push_back(3);

`ifdef CTRL_ILLEGAL_TRAP_EN
    run(32'h0000007F, 8, -1);
    lit("illegal_held", int'(bus.illegalInstr), 1);
    reset_cycle();
    lit("illegal_cleared", int'(bus.illegalInstr), 0);
    run(32'h002081B3, 3, 0);
    exp_cpi_q.push_back(3);
`else
    run(32'h0000007F, 3, -1);
    exp_cpi_q.push_back(3);
`endif

    chk_en = 1'b0;
    lit("done_count", done_q.size(), exp_cpi_q.size());
    for (int i = 0; i < exp_cpi_q.size() && i < done_q.size(); i++)
      lit($sformatf("cpi_%0d", i), done_q[i], exp_cpi_q[i]);
    lit("busWe_cycles", bwe_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
